// File: rtl/rotary_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : rotary_decoder_mc
// Purpose  : Multi-channel quadrature decoder for PmodENC-style rotary
//            encoders. Each channel synchronises and debounces its A/B
//            contacts, arms on a stable resting position, then decodes
//            rotation into a one-cycle event with direction. It also keeps a
//            signed position counter and a sticky pending flag that is
//            cleared by an acknowledge.
// Build    : define ROTARY_X4_EN for x4 decoding (4 events per detent).
//            Without it the channel decodes x1 (1 event per detent).
// Ports    : clk            system clock, rising edge
//            reset_n        synchronous active-low reset
//            rotary_a/b     raw asynchronous contacts, bit i = channel i
//            cnt_clear      per-channel counter clear (next edge)
//            rotary_ack     per-channel pending clear (next edge)
//            rotary_event   one-cycle pulse per decoded step
//            rotary_left    direction of last step (1 = left), held
//            rotary_pending sticky "step since last ack"
//            rotary_count   signed counters, field i = [i*CNT_WIDTH +: CNT_WIDTH]
//            rotary_ready   channel is past ARM and decoding
// Revision : 1.0 - initial release
// ============================================================================
module rotary_decoder_mc #(
    parameter int NUM_CH     = 1,
    parameter int CNT_WIDTH  = 16,
    parameter int FILTER_LEN = 4,
    parameter int SATURATE   = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           rotary_a,
    input  logic [NUM_CH-1:0]           rotary_b,
    input  logic [NUM_CH-1:0]           cnt_clear,
    input  logic [NUM_CH-1:0]           rotary_ack,
    output logic [NUM_CH-1:0]           rotary_event,
    output logic [NUM_CH-1:0]           rotary_left,
    output logic [NUM_CH-1:0]           rotary_pending,
    output logic [NUM_CH*CNT_WIDTH-1:0] rotary_count,
    output logic [NUM_CH-1:0]           rotary_ready
);

    localparam logic [7:0]           c_FILT    = 8'(FILTER_LEN);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

`ifdef ROTARY_X4_EN
    // Position of a (b,a) code along the left-turn sequence 00,10,11,01.
    // A left step advances this index by one, a right step retreats by one.
    function automatic logic [1:0] f_phase(input logic [1:0] ba);
        case (ba)
            2'b00:   f_phase = 2'd0;
            2'b10:   f_phase = 2'd1;
            2'b11:   f_phase = 2'd2;
            default: f_phase = 2'd3;
        endcase
    endfunction
`endif

    // Marks when the two-stage synchronisers hold a real post-reset sample,
    // so the arming window never counts the flushed reset value.
    logic [1:0] r_sync_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_vld <= 2'b00;
        end else begin
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]           w_raw;      // {b, a}
        logic [1:0]           w_lvl;      // debounced {b, a}
        logic [1:0]           w_done;     // debounce window complete per bit
        logic                 w_arming;
        logic                 w_arm_exit;
        state_t               r_state;
        state_t               w_state_next;
        logic                 r_step;
        logic                 r_step_left;
        logic                 r_event;
        logic                 r_left;
        logic                 r_pending;
        logic [CNT_WIDTH-1:0] r_count;
        logic [CNT_WIDTH-1:0] w_count_next;

        assign w_raw    = {rotary_b[i], rotary_a[i]};
        assign w_arming = (r_state == ST_ARM);

        // ---------------------------------------------------------------
        // Synchroniser and debounce, one instance per contact
        // ---------------------------------------------------------------
        for (genvar j = 0; j < 2; j++) begin : g_bit
            logic       r_s1;
            logic       r_s2;
            logic       r_lvl;
            logic [7:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_lvl <= 1'b0;
                    r_cnt <= 8'd0;
                end else begin
                    r_s1 <= w_raw[j];
                    r_s2 <= r_s1;
                    if (w_arming) begin
                        // Arming: the first real sample becomes the reference
                        // and must repeat for a full window. A change restarts
                        // the window on the new value; a finished window holds
                        // until the other contact is done too.
                        if (w_arm_exit) begin
                            r_cnt <= 8'd0;
                        end else if (!r_sync_vld[1]) begin
                            r_cnt <= 8'd0;
                        end else if (r_cnt != c_FILT) begin
                            if (r_cnt == 8'd0 || r_s2 != r_lvl) begin
                                r_lvl <= r_s2;
                                r_cnt <= 8'd1;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end else begin
                        if (r_cnt == c_FILT) begin
                            r_lvl <= r_s2;
                            r_cnt <= 8'd0;
                        end else if (r_s2 != r_lvl) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else begin
                            r_cnt <= 8'd0;
                        end
                    end
                end
            end

            assign w_lvl[j]  = r_lvl;
            assign w_done[j] = (r_cnt == c_FILT);
        end

        // ---------------------------------------------------------------
        // Channel state machine
        // ---------------------------------------------------------------
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state <= ST_ARM;
            end else begin
                r_state <= w_state_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_arm_exit   = 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (&w_done) begin
                        w_arm_exit   = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN:  w_state_next = ST_RUN;
                default: w_state_next = ST_ARM;
            endcase
        end

        // ---------------------------------------------------------------
        // Decode stage: produces a registered step and its direction
        // ---------------------------------------------------------------
`ifdef ROTARY_X4_EN
        logic [1:0] r_ba_prev;
        logic [1:0] w_diff;
        logic [1:0] w_prev_inc;
        logic       w_single;
        logic       w_dir_left;

        assign w_diff     = w_lvl ^ r_ba_prev;
        // Exactly one contact moved; both moving at once is not a legal step.
        assign w_single   = w_diff[0] ^ w_diff[1];
        assign w_prev_inc = f_phase(r_ba_prev) + 2'd1;
        assign w_dir_left = (f_phase(w_lvl) == w_prev_inc);

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_ba_prev   <= 2'b00;
                r_step      <= 1'b0;
                r_step_left <= 1'b0;
            end else if (w_arm_exit) begin
                r_ba_prev   <= w_lvl;
                r_step      <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_ba_prev   <= w_lvl;
                r_step      <= w_single;
                r_step_left <= w_dir_left;
            end else begin
                r_step      <= 1'b0;
            end
        end
`else
        logic r_q1;
        logic r_q2;
        logic w_q1_next;
        logic w_q2_next;

        // One-hot offset filter: q1 tracks the 00/11 extremes, q2 remembers
        // which side (01 vs 10) was last visited and so the direction.
        always_comb begin
            w_q1_next = r_q1;
            w_q2_next = r_q2;
            case (w_lvl)
                2'b00:   w_q1_next = 1'b0;
                2'b11:   w_q1_next = 1'b1;
                2'b01:   w_q2_next = 1'b0;
                default: w_q2_next = 1'b1;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_q1        <= 1'b0;
                r_q2        <= 1'b0;
                r_step      <= 1'b0;
                r_step_left <= 1'b0;
            end else if (w_arm_exit) begin
                // Start from the resting position so no step is produced.
                r_q1        <= w_lvl[1] & w_lvl[0];
                r_q2        <= w_lvl[1] & ~w_lvl[0];
                r_step      <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_q1        <= w_q1_next;
                r_q2        <= w_q2_next;
                r_step      <= w_q1_next & ~r_q1;
                r_step_left <= w_q2_next;
            end else begin
                r_step      <= 1'b0;
            end
        end
`endif

        // ---------------------------------------------------------------
        // Output stage: event, direction, pending and position counter
        // ---------------------------------------------------------------
        always_comb begin
            w_count_next = r_count;
            if (r_step_left) begin
                if (SATURATE != 0 && r_count == c_CNT_MIN) begin
                    w_count_next = r_count;
                end else begin
                    w_count_next = r_count - c_CNT_ONE;
                end
            end else begin
                if (SATURATE != 0 && r_count == c_CNT_MAX) begin
                    w_count_next = r_count;
                end else begin
                    w_count_next = r_count + c_CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_event   <= 1'b0;
                r_left    <= 1'b0;
                r_pending <= 1'b0;
                r_count   <= '0;
            end else begin
                r_event <= r_step;
                if (r_step) begin
                    r_left <= r_step_left;
                end
                // A step in the same cycle as an ack keeps pending set.
                if (r_step) begin
                    r_pending <= 1'b1;
                end else if (rotary_ack[i]) begin
                    r_pending <= 1'b0;
                end
                // Clear has priority over a coincident step.
                if (cnt_clear[i]) begin
                    r_count <= '0;
                end else if (r_step) begin
                    r_count <= w_count_next;
                end
            end
        end

        assign rotary_event[i]                         = r_event;
        assign rotary_left[i]                          = r_left;
        assign rotary_pending[i]                       = r_pending;
        assign rotary_count[i*CNT_WIDTH +: CNT_WIDTH]  = r_count;
        assign rotary_ready[i]                         = (r_state == ST_RUN);
    end

endmodule
`default_nettype wire
